// File: rtl/mem_arbiter.sv
// Memory-side arbiter between the icache/dcache request ports and the single RAM port.
// The dcache wins ties when idle. After a transaction completes, the grant passes to the
// other port if it is requesting, so contending ports alternate. RAM ERROR responses are
// retried after a one-cycle backoff, up to RETRY_MAX times. After that the transaction
// completes with a buserr pulse.
module mem_arbiter #(
   parameter int RETRY_MAX = 3,
   parameter int AW        = 32
) (
   input  logic          CLK,
   input  logic          nRST,
   input  logic          iREN,
   input  logic [AW-1:0] iaddr,
   output logic          iwait,
   output logic [31:0]   iload,
   input  logic          dREN,
   input  logic          dWEN,
   input  logic [AW-1:0] daddr,
   input  logic [31:0]   dstore,
   output logic          dwait,
   output logic [31:0]   dload,
   output logic          ramREN,
   output logic          ramWEN,
   output logic [AW-1:0] ramaddr,
   output logic [31:0]   ramstore,
   input  logic [31:0]   ramload,
   input  logic [1:0]    ramstate,
   output logic          buserr
);

   localparam int CW = $clog2(RETRY_MAX + 2);
   localparam logic [1:0] RS_ACCESS = 2'b10;
   localparam logic [1:0] RS_ERROR  = 2'b11;

   typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, BACKOFF} state_t;

   state_t        state, state_next;
   logic          owner_d, owner_d_next;
   logic [CW-1:0] cnt, cnt_next;

   logic   d_req;
   logic   retries_spent;
   logic   finish_now;
   state_t idle_pick;

   assign d_req         = dREN | dWEN;
   assign retries_spent = (cnt == CW'(RETRY_MAX));
   assign finish_now    = (ramstate == RS_ACCESS) || ((ramstate == RS_ERROR) && retries_spent);
   assign idle_pick     = d_req ? GNT_D : (iREN ? GNT_I : IDLE);

   // Load data is passed straight through; held at zero while reset is asserted
   assign iload = nRST ? ramload : 32'h0;
   assign dload = nRST ? ramload : 32'h0;

   // State, retry owner and retry counter registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state   <= IDLE;
         owner_d <= 1'b0;
         cnt     <= '0;
      end else begin
         state   <= state_next;
         owner_d <= owner_d_next;
         cnt     <= cnt_next;
      end
   end

   // Arbitration, retry handling and RAM strobe/wait generation
   always_comb begin
      state_next   = state;
      owner_d_next = owner_d;
      cnt_next     = cnt;
      iwait        = 1'b1;
      dwait        = 1'b1;
      ramREN       = 1'b0;
      ramWEN       = 1'b0;
      ramaddr      = '0;
      ramstore     = 32'h0;
      buserr       = 1'b0;
      case (state)
         IDLE: begin
            cnt_next   = '0;
            state_next = idle_pick;
         end
         GNT_I: begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
            if (!iREN) begin
               cnt_next   = '0;
               state_next = idle_pick;
            end else if (finish_now) begin
               iwait      = 1'b0;
               buserr     = (ramstate == RS_ERROR);
               cnt_next   = '0;
               state_next = d_req ? GNT_D : IDLE;
            end else if (ramstate == RS_ERROR) begin
               cnt_next     = cnt + 1'b1;
               owner_d_next = 1'b0;
               state_next   = BACKOFF;
            end
         end
         GNT_D: begin
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
            if (!d_req) begin
               cnt_next   = '0;
               state_next = idle_pick;
            end else if (finish_now) begin
               dwait      = 1'b0;
               buserr     = (ramstate == RS_ERROR);
               cnt_next   = '0;
               state_next = iREN ? GNT_I : IDLE;
            end else if (ramstate == RS_ERROR) begin
               cnt_next     = cnt + 1'b1;
               owner_d_next = 1'b1;
               state_next   = BACKOFF;
            end
         end
         BACKOFF: begin
            if (owner_d ? d_req : iREN) begin
               state_next = owner_d ? GNT_D : GNT_I;
            end else begin
               cnt_next   = '0;
               state_next = idle_pick;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a RAM model with a scripted ramstate sequence, cache-side
// request agents, and a completion scoreboard keyed per port.
module tb_mem_arbiter;

   localparam logic [1:0] RS_FREE   = 2'b00;
   localparam logic [1:0] RS_BUSY   = 2'b01;
   localparam logic [1:0] RS_ACCESS = 2'b10;
   localparam logic [1:0] RS_ERROR  = 2'b11;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      logic        berr;
   } exp_t;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        iREN = 1'b0;
   logic [31:0] iaddr = 32'h0;
   logic        iwait;
   logic [31:0] iload;
   logic        dREN = 1'b0;
   logic        dWEN = 1'b0;
   logic [31:0] daddr = 32'h0;
   logic [31:0] dstore = 32'h0;
   logic        dwait;
   logic [31:0] dload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic [1:0]  ramstate;
   logic        buserr;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int gaps = 0;

   logic [1:0] plan [16];
   int         plen = 0;
   int         pidx = 0;
   int         plan_gen = 0;
   int         seen_gen = 0;

   logic        manual = 1'b1;
   logic        i_acc = 1'b0;
   logic        d_acc = 1'b0;
   logic [31:0] i_pending [$];
   exp_t        d_pending [$];
   exp_t        i_exp [$];
   exp_t        d_exp [$];
   exp_t        mon_e;
   logic [31:0] tmp_a;
   exp_t        tmp_e;
   logic        order_q [$];
   int          done_cyc [$];

   mem_arbiter #(.RETRY_MAX(3), .AW(32)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .buserr(buserr)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] ram_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
   endfunction

   // RAM model: scripted ramstate per strobed cycle, ACCESS once the script runs out
   assign ramstate = (ramREN || ramWEN) ? ((pidx < plen) ? plan[pidx] : RS_ACCESS) : RS_FREE;
   assign ramload  = ramREN ? ram_word(ramaddr) : 32'hCAFE_0000;

   always @(posedge CLK) begin
      cyc <= cyc + 1;
      if (plan_gen != seen_gen) begin
         seen_gen <= plan_gen;
         pidx     <= 0;
      end else if ((ramREN || ramWEN) && pidx < plen) begin
         pidx <= pidx + 1;
      end
   end

   task automatic set_plan(input logic [1:0] st, input int n);
      for (int k = 0; k < 16; k++) plan[k] = st;
      plen = n;
      plan_gen++;
   endtask

   task automatic queue_i(input logic [31:0] a, input logic berr);
      exp_t e;
      e.we = 1'b0; e.addr = a; e.data = ram_word(a); e.berr = berr;
      i_pending.push_back(a);
      i_exp.push_back(e);
   endtask

   task automatic queue_d(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic berr);
      exp_t e;
      e.we = we; e.addr = a; e.data = we ? wd : ram_word(a); e.berr = berr;
      d_pending.push_back(e);
      d_exp.push_back(e);
   endtask

   // Cache-side agents: hold each request until its wait goes low, then present the next
   always @(posedge CLK) begin
      #1;
      if (!manual) begin
         if (i_acc && i_pending.size() > 0) tmp_a = i_pending.pop_front();
         if (d_acc && d_pending.size() > 0) tmp_e = d_pending.pop_front();
         if (i_pending.size() > 0) begin
            iREN = 1'b1; iaddr = i_pending[0];
         end else begin
            iREN = 1'b0;
         end
         if (d_pending.size() > 0) begin
            dWEN = d_pending[0].we; dREN = ~d_pending[0].we;
            daddr = d_pending[0].addr; dstore = d_pending[0].data;
         end else begin
            dWEN = 1'b0; dREN = 1'b0;
         end
      end
   end

   // Scoreboard monitor: every wait-low cycle must match the oldest expectation of that port
   always @(negedge CLK) begin
      if (nRST) begin
         i_acc = iREN && !iwait;
         d_acc = (dREN || dWEN) && !dwait;
         if (!iwait && !dwait) begin
            checks++; errors++;
            $display("[TB] FAIL both_waits_low iwait=%b dwait=%b required one high", iwait, dwait);
         end
         if (!iwait) begin
            checks++;
            if (i_exp.size() == 0) begin
               errors++;
               $display("[TB] FAIL i_unexpected iwait=0 at cycle %0d required 1", cyc);
            end else begin
               mon_e = i_exp.pop_front();
               if (iload !== mon_e.data || ramaddr !== mon_e.addr || ramREN !== 1'b1 || buserr !== mon_e.berr) begin
                  errors++;
                  $display("[TB] FAIL i_done iload=%h addr=%h ren=%b berr=%b required %h %h 1 %b",
                           iload, ramaddr, ramREN, buserr, mon_e.data, mon_e.addr, mon_e.berr);
               end
            end
            order_q.push_back(1'b0);
            done_cyc.push_back(cyc);
         end
         if (!dwait) begin
            checks++;
            if (d_exp.size() == 0) begin
               errors++;
               $display("[TB] FAIL d_unexpected dwait=0 at cycle %0d required 1", cyc);
            end else begin
               mon_e = d_exp.pop_front();
               if (mon_e.we) begin
                  if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== mon_e.addr ||
                      ramstore !== mon_e.data || buserr !== mon_e.berr) begin
                     errors++;
                     $display("[TB] FAIL d_write wen=%b ren=%b addr=%h store=%h berr=%b required 1 0 %h %h %b",
                              ramWEN, ramREN, ramaddr, ramstore, buserr, mon_e.addr, mon_e.data, mon_e.berr);
                  end
               end else begin
                  if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== mon_e.addr ||
                      dload !== mon_e.data || buserr !== mon_e.berr) begin
                     errors++;
                     $display("[TB] FAIL d_read ren=%b wen=%b addr=%h dload=%h berr=%b required 1 0 %h %h %b",
                              ramREN, ramWEN, ramaddr, dload, buserr, mon_e.addr, mon_e.data, mon_e.berr);
                  end
               end
            end
            order_q.push_back(1'b1);
            done_cyc.push_back(cyc);
         end
         if (iwait && dwait && buserr) begin
            checks++; errors++;
            $display("[TB] FAIL stray_buserr buserr=1 without completion required 0");
         end
         if ((iREN || dREN || dWEN) && !ramREN && !ramWEN) gaps++;
      end else begin
         i_acc = 1'b0;
         d_acc = 1'b0;
      end
   end

   task automatic test_reset();
      nRST = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      checks++;
      if (iwait !== 1'b1 || dwait !== 1'b1) begin
         errors++; $display("[TB] FAIL reset_waits iwait=%b dwait=%b required 1 1", iwait, dwait);
      end
      checks++;
      if (ramREN !== 1'b0 || ramWEN !== 1'b0 || buserr !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_strobes ren=%b wen=%b berr=%b required 0 0 0", ramREN, ramWEN, buserr);
      end
      checks++;
      if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin
         errors++; $display("[TB] FAIL reset_bus addr=%h store=%h required 0 0", ramaddr, ramstore);
      end
      checks++;
      if (iload !== 32'h0 || dload !== 32'h0) begin
         errors++; $display("[TB] FAIL reset_load iload=%h dload=%h required 0 0", iload, dload);
      end
      @(posedge CLK); #2;
      nRST = 1'b1;
   endtask

   task automatic test_single_read();
      @(posedge CLK); #1;
      set_plan(RS_BUSY, 2);
      iREN = 1'b1; iaddr = 32'h40;
      i_exp.push_back('{1'b0, 32'h40, ram_word(32'h40), 1'b0});
      @(negedge CLK);
      checks++;
      if (ramREN !== 1'b0 || iwait !== 1'b1) begin
         errors++; $display("[TB] FAIL t1_arb_cycle ren=%b iwait=%b required 0 1", ramREN, iwait);
      end
      @(negedge CLK);
      checks++;
      if (ramREN !== 1'b1 || ramaddr !== 32'h40 || iwait !== 1'b1) begin
         errors++; $display("[TB] FAIL t1_grant ren=%b addr=%h iwait=%b required 1 00000040 1", ramREN, ramaddr, iwait);
      end
      @(negedge CLK);
      checks++;
      if (iwait !== 1'b1) begin
         errors++; $display("[TB] FAIL t1_busy iwait=%b required 1", iwait);
      end
      @(negedge CLK);
      checks++;
      if (iwait !== 1'b0) begin
         errors++; $display("[TB] FAIL t1_access iwait=%b required 0", iwait);
      end
      @(posedge CLK); #1;
      iREN = 1'b0;
      @(negedge CLK);
      checks++;
      if (ramREN !== 1'b0 || iwait !== 1'b1) begin
         errors++; $display("[TB] FAIL t1_idle ren=%b iwait=%b required 0 1", ramREN, iwait);
      end
   endtask

   task automatic test_priority();
      @(posedge CLK); #2;
      set_plan(RS_ACCESS, 0);
      order_q.delete(); done_cyc.delete();
      manual = 1'b0;
      queue_d(1'b1, 32'h80, 32'hDEADBEEF, 1'b0);
      queue_i(32'h44, 1'b0);
      for (int k = 0; k < 100; k++) begin
         if (i_pending.size() == 0 && d_pending.size() == 0) break;
         @(posedge CLK); #2;
      end
      checks++;
      if (i_pending.size() != 0 || d_pending.size() != 0) begin
         errors++; $display("[TB] FAIL t2_timeout pending i=%0d d=%0d required 0 0", i_pending.size(), d_pending.size());
      end
      checks++;
      if (order_q.size() != 2 || order_q[0] !== 1'b1 || order_q[1] !== 1'b0) begin
         errors++; $display("[TB] FAIL t2_order count=%0d required 2 with D first", order_q.size());
      end else begin
         checks++;
         if (done_cyc[1] - done_cyc[0] != 1) begin
            errors++; $display("[TB] FAIL t2_no_gap gap=%0d required 1", done_cyc[1] - done_cyc[0]);
         end
      end
   endtask

   task automatic test_alternation();
      int bad;
      @(posedge CLK); #2;
      set_plan(RS_ACCESS, 0);
      order_q.delete(); done_cyc.delete();
      for (int k = 0; k < 3; k++) begin
         queue_d(1'b0, 32'h1000 + 32'(4 * k), 32'h0, 1'b0);
         queue_i(32'h2000 + 32'(4 * k), 1'b0);
      end
      for (int k = 0; k < 200; k++) begin
         if (i_pending.size() == 0 && d_pending.size() == 0) break;
         @(posedge CLK); #2;
      end
      bad = (order_q.size() != 6) ? 1 : 0;
      for (int k = 0; k < order_q.size() && k < 6; k++)
         if (order_q[k] !== ((k % 2) == 0)) bad++;
      checks++;
      if (bad != 0) begin
         errors++; $display("[TB] FAIL t3_alternate count=%0d wrong=%0d required 6 in D,I order", order_q.size(), bad);
      end
   endtask

   task automatic test_retry();
      logic [1:0] err_n [3] = '{2'd2, 2'd0, 2'd1};
      int         want_gaps [3] = '{3, 4, 2};
      for (int t = 0; t < 3; t++) begin
         @(posedge CLK); #2;
         set_plan(RS_ERROR, (t == 1) ? 4 : int'(err_n[t]));
         gaps = 0;
         if (t == 2) queue_i(32'h500, 1'b0);
         else queue_d(1'b0, 32'h100 + 32'(4 * t), 32'h0, t == 1);
         for (int k = 0; k < 100; k++) begin
            if (i_pending.size() == 0 && d_pending.size() == 0) break;
            @(posedge CLK); #2;
         end
         @(negedge CLK);
         checks++;
         if (gaps != want_gaps[t] || i_exp.size() != 0 || d_exp.size() != 0) begin
            errors++; $display("[TB] FAIL t4_retry%0d gaps=%0d open=%0d required %0d 0",
                               t, gaps, i_exp.size() + d_exp.size(), want_gaps[t]);
         end
      end
   endtask

   task automatic test_abort();
      @(posedge CLK); #1;
      manual = 1'b1;
      set_plan(RS_BUSY, 8);
      iREN = 1'b1; iaddr = 32'h200;
      @(negedge CLK);
      @(negedge CLK);
      checks++;
      if (ramREN !== 1'b1 || ramaddr !== 32'h200) begin
         errors++; $display("[TB] FAIL t5_grant ren=%b addr=%h required 1 00000200", ramREN, ramaddr);
      end
      @(posedge CLK); #1;
      iREN = 1'b0;
      @(negedge CLK);
      checks++;
      if (iwait !== 1'b1) begin
         errors++; $display("[TB] FAIL t5_drop iwait=%b required 1", iwait);
      end
      @(negedge CLK);
      checks++;
      if (ramREN !== 1'b0 || iwait !== 1'b1) begin
         errors++; $display("[TB] FAIL t5_release ren=%b iwait=%b required 0 1", ramREN, iwait);
      end
   endtask

   task automatic test_reset_mid();
      @(posedge CLK); #1;
      set_plan(RS_BUSY, 10);
      dWEN = 1'b1; daddr = 32'h300; dstore = 32'h0BADF00D;
      @(negedge CLK);
      @(negedge CLK);
      checks++;
      if (ramWEN !== 1'b1 || ramstore !== 32'h0BADF00D) begin
         errors++; $display("[TB] FAIL t6_grant wen=%b store=%h required 1 0badf00d", ramWEN, ramstore);
      end
      #2;
      nRST = 1'b0;
      #1;
      checks++;
      if (ramWEN !== 1'b0 || dwait !== 1'b1 || ramaddr !== 32'h0) begin
         errors++; $display("[TB] FAIL t6_async wen=%b dwait=%b addr=%h required 0 1 0", ramWEN, dwait, ramaddr);
      end
      @(posedge CLK); #2;
      set_plan(RS_ACCESS, 0);
      d_exp.push_back('{1'b1, 32'h300, 32'h0BADF00D, 1'b0});
      nRST = 1'b1;
      @(negedge CLK);
      checks++;
      if (ramWEN !== 1'b0 || dwait !== 1'b1) begin
         errors++; $display("[TB] FAIL t6_idle wen=%b dwait=%b required 0 1", ramWEN, dwait);
      end
      @(negedge CLK);
      checks++;
      if (dwait !== 1'b0) begin
         errors++; $display("[TB] FAIL t6_regrant dwait=%b required 0", dwait);
      end
      @(posedge CLK); #1;
      dWEN = 1'b0;
      @(negedge CLK);
      checks++;
      if (i_exp.size() != 0 || d_exp.size() != 0) begin
         errors++; $display("[TB] FAIL final_open open=%0d required 0", i_exp.size() + d_exp.size());
      end
   endtask

   initial begin
      $display("[TB] mem_arbiter bench start");
      test_reset();
      test_single_read();
      test_priority();
      test_alternation();
      test_retry();
      test_abort();
      test_reset_mid();
      repeat (2) @(posedge CLK);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout time limit reached required finish");
      $fatal(1, "[TB] timeout");
   end

endmodule
